// File: rtl/datapath_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_pkg
// Shared types and constants for the datapath controller:
//   - state_t        : controller FSM states
//   - OPC_* / OP_*   : opcode and op-field encodings of the supported ISA
//   - ALU_*          : ALUop encodings understood by the datapath ALU
//   - *_LSB          : bit positions of the instruction fields
//   - op_to_aluop()  : op field -> ALUop
// -----------------------------------------------------------------------------
package datapath_ctrl_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
  } state_t;

  // Opcode field instr[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // Op field instr[12:11] under OPC_MOV
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;

  // Op field instr[12:11] under OPC_ALU
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Field LSB positions (widths: opcode 3, op 2, Rn/Rd/Rm 3, sh 2)
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  // The ALU op field maps one-to-one onto the ALU encodings; MOV reg has
  // op=00 and therefore computes ADD (with A forced to zero).
  function automatic logic [1:0] op_to_aluop(input logic [1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_CMP:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_MVN:  return ALU_NOTB;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_if
// Bundles the instruction handshake and the datapath control bus.
//   master : the controller (takes s/instr, drives w and all datapath controls)
//   slave  : instruction source + datapath (drives s/instr, observes the rest)
// Signals: s, instr, w, readnum, writenum, write, vsel, loada, loadb, loadc,
//          loads, asel, bsel, shift, ALUop, datapath_in
//          and illegal when DATAPATH_CTRL_ILLEGAL_EN is defined.
// -----------------------------------------------------------------------------
interface datapath_ctrl_if #(
  parameter int DATA_W = 16
);

  logic              s;
  logic [15:0]       instr;
  logic              w;
  logic [2:0]        readnum;
  logic [2:0]        writenum;
  logic              write;
  logic              vsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic [1:0]        shift;
  logic [1:0]        ALUop;
  logic [DATA_W-1:0] datapath_in;
`ifdef DATAPATH_CTRL_ILLEGAL_EN
  logic              illegal;

  modport master (
    input  s, instr,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in, illegal
  );

  modport slave (
    output s, instr,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in, illegal
  );
`else
  modport master (
    input  s, instr,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in
  );

  modport slave (
    output s, instr,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in
  );
`endif

endinterface

// File: rtl/instr_dec.sv
// -----------------------------------------------------------------------------
// instr_dec
// Purely combinational decode of the latched instruction.
// Inputs : instr    - latched 16-bit instruction
// Outputs: rn/rd/rm - register fields; op, sh - op and shift fields
//          sximm    - imm8 sign-extended to DATA_W
//          is_movi, is_movr, is_alu, is_cmp - instruction class flags
//          needs_a  - instruction reads Rn into A (ADD/CMP/AND)
//          illegal  - encoding is none of the supported instructions
// -----------------------------------------------------------------------------
module instr_dec
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [2:0]         rn,
  output logic [2:0]         rd,
  output logic [2:0]         rm,
  output logic [1:0]         op,
  output logic [1:0]         sh,
  output logic [DATA_W-1:0]  sximm,
  output logic               is_movi,
  output logic               is_movr,
  output logic               is_alu,
  output logic               is_cmp,
  output logic               needs_a,
  output logic               illegal
);

  logic [2:0] opcode;

  assign opcode = instr[OPC_LSB +: 3];
  assign op     = instr[OP_LSB  +: 2];
  assign rn     = instr[RN_LSB  +: 3];
  assign rd     = instr[RD_LSB  +: 3];
  assign sh     = instr[SH_LSB  +: 2];
  assign rm     = instr[RM_LSB  +: 3];

  assign sximm  = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
  assign is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
  assign is_alu  = (opcode == OPC_ALU);
  assign is_cmp  = is_alu && (op == OP_CMP);
  // MVN is the only ALU-class instruction that does not use Rn.
  assign needs_a = is_alu && (op != OP_MVN);
  assign illegal = !(is_movi || is_movr || is_alu);

endmodule

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
// Moore FSM that accepts one instruction per start pulse and sequences the
// register-file / shifter / ALU datapath cycle by cycle.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset (state=WAIT, instruction reg=0)
//   bus      - datapath_ctrl_if.master: s/instr in; w, readnum, writenum,
//              write, vsel, loada/b/c/s, asel, bsel, shift, ALUop,
//              datapath_in out
// Optional: define DATAPATH_CTRL_ILLEGAL_EN to add bus.illegal, a sticky flag
// set when an unsupported encoding is decoded and cleared on the next accept.
// -----------------------------------------------------------------------------
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input logic            clk,
  input logic            reset_n,
  datapath_ctrl_if.master bus
);

  state_t               state;
  state_t               next_state;
  logic [INSTR_W-1:0]   ir;

  logic [2:0]           rn, rd, rm;
  logic [1:0]           op, sh;
  logic [DATA_W-1:0]    sximm;
  logic                 is_movi, is_movr, is_alu, is_cmp, needs_a, illegal;

  logic                 accept;

  instr_dec #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_dec (
    .instr   (ir),
    .rn      (rn),
    .rd      (rd),
    .rm      (rm),
    .op      (op),
    .sh      (sh),
    .sximm   (sximm),
    .is_movi (is_movi),
    .is_movr (is_movr),
    .is_alu  (is_alu),
    .is_cmp  (is_cmp),
    .needs_a (needs_a),
    .illegal (illegal)
  );

  assign accept = (state == S_WAIT) && bus.s;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (accept) ir <= bus.instr;
    end
  end

`ifdef DATAPATH_CTRL_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          illegal_q <= 1'b0;
    else if (accept)                       illegal_q <= 1'b0;
    else if (state == S_DECODE && illegal) illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`endif

  // Outputs are a pure function of state and the latched instruction, so an
  // asynchronous reset drops them to their idle values immediately.
  assign bus.w           = (state == S_WAIT);
  assign bus.datapath_in = sximm;

  // NOTE: every signal written below gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    next_state   = state;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = '0;
    bus.ALUop    = '0;

    case (state)
      S_WAIT: begin
        if (bus.s) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (illegal)      next_state = S_WAIT;
        else if (is_movi) next_state = S_WRITE_IMM;
        else if (needs_a) next_state = S_GET_A;
        else              next_state = S_GET_B;   // MOV reg, MVN
      end
      S_WRITE_IMM: begin
        bus.vsel     = 1'b1;
        bus.writenum = rn;
        bus.write    = 1'b1;
        next_state   = S_WAIT;
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        next_state  = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        next_state  = S_ALU;
      end
      S_ALU: begin
        bus.shift  = sh;
        bus.ALUop  = op_to_aluop(op);
        // Zeroing A turns the ADD of MOV reg into a pass-through of shifted
        // Rm; for MVN the A input is simply ignored by NOT B.
        bus.asel   = is_movr || (is_alu && !needs_a);
        bus.loadc  = 1'b1;
        bus.loads  = is_cmp;
        next_state = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        next_state   = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle Moore FSM that sequences the 16-bit register-file/shifter/ALU datapath (ports clk, readnum, vsel, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, write, datapath_in, Z_out, datapath_out).
- Accepts one 16-bit instruction per start pulse, decodes it, and drives the datapath controls cycle by cycle. This replaces hand-driven control sequences.
- Sits between the instruction source and the datapath; w=1 signals ready for the next instruction.

Parameters:
- DATA_W, 16, datapath width; width of datapath_in and sign-extension target.
- IMM_W, 8, immediate field width, instr[IMM_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s  in  1  start; sampled only in WAIT.
- instr  in  16  instruction; latched when s=1 in WAIT.
- w  out  1  1 in WAIT (ready), else 0.
- readnum  out  3  register-file read address.
- writenum  out  3  register-file write address.
- write  out  1  register-file write enable.
- vsel  out  1  1 selects datapath_in, 0 selects C for writeback.
- loada, loadb, loadc, loads  out  1 each  datapath register loads.
- asel, bsel  out  1 each  1 selects zero for A / sximm path for B (bsel always 0 here).
- shift  out  2  shifter control.
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B.
- datapath_in  out  DATA_W  sign-extended imm8.

Behaviour:
- Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0]. The instruction register is loaded only on WAIT && s.
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - Anything else is illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- Transitions:
  - WAIT: s=1 goes to DECODE, else stay in WAIT.
  - DECODE: MOV imm goes to WRITE_IMM; ADD/CMP/AND go to GET_A; MOV reg/MVN go to GET_B; illegal goes to WAIT.
  - GET_A goes to GET_B. GET_B goes to ALU.
  - ALU: CMP goes to WAIT; otherwise goes to WRITE_REG.
  - WRITE_REG and WRITE_IMM go to WAIT.
- Default outputs (all states unless overridden below): every load/write/asel/bsel/vsel is 0; readnum, writenum, shift, ALUop are 0; datapath_in = sximm8 of the latched instruction (0 after reset).
- Per-state outputs:
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU: shift=sh; ALUop=op; asel=1 for MOV reg/MVN, else 0; loadc=1; loads=1 only for CMP. MOV reg therefore computes 0+shifted Rm.
  - WRITE_REG: vsel=0, writenum=Rd, write=1.
  - WRITE_IMM: vsel=1, writenum=Rn, write=1.
- Busy cycles between s accepted and w returning to 1: MOV imm 2, MOV reg/MVN 4, CMP 4, ADD/AND 5, illegal 1.
- Sign extension: datapath_in = {{(DATA_W-IMM_W){imm8[7]}}, imm8}.
- Boundary conditions:
  - s while busy: ignored; instr changes while busy have no effect.
  - s held high: a new instruction is accepted on the first WAIT cycle.
  - reset_n low at any time: state=WAIT, instruction register=0, and all outputs go to defaults with w=1, immediately (asynchronous). No partial write occurs after reset.
  - Rd=Rn or Rm: legal; operands were captured in A/B before the write.

Optional Feature:
- Macro DATAPATH_CTRL_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit). It is set when DECODE sees an unsupported encoding, cleared when the next instruction is accepted, and reset to 0.
- Undefined: no port; illegal encodings silently return to WAIT with no datapath activity.

Decomposition:
- Package datapath_ctrl_pkg holds:
  - state enum
  - opcode/op localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD..OP_MVN)
  - ALUop encodings
  - field bit-position constants
- Sub-module instr_dec (combinational): field extraction, sign extension, instruction-class flags (is_movi, is_movr, is_alu, is_cmp, needs_a, illegal).

Test Plan:
- MOV R0,#7 (0xD007) then MOV R1,#2 (0xD102) -> each: one WRITE_IMM cycle with writenum=0/1, vsel=1, datapath_in=0x0007/0x0002; w=0 for exactly 2 cycles.
- ADD R2,R1,R0,LSL#1 (0xA148) with datapath attached -> readnum 1 then 0, shift=01, ALUop=00, writenum=2; R2 reads back 16 (0x0010); 5 busy cycles.
- CMP R0,R1 (0xA801) after above -> loads=1 in ALU, ALUop=01, write never asserted; 4 busy cycles; Z_out=0.
- MOV R4,#-1 (0xD4FF) then MVN R3,R4 (0xB860 with Rm=4, i.e. 0xB864) -> datapath_in=0xFFFF; R3=0x0000; asel=1 in ALU.
- Illegal 0xE000 -> returns to WAIT after DECODE with no load/write; with DATAPATH_CTRL_ILLEGAL_EN, illegal=1 until the next accepted s.
- reset_n asserted during ADD in the ALU state -> w=1 and write=0 asynchronously; R2 is unchanged; s pulsed again after release restarts cleanly.
